// File: rtl/vproc_pkg.sv
// Shared types for the vector dispatch path: execution-unit selector and
// dispatcher entry state.
package vproc_pkg;

    typedef enum logic [2:0] {
        UNIT_ALU  = 3'd0,
        UNIT_MUL  = 3'd1,
        UNIT_LSU  = 3'd2,
        UNIT_SLD  = 3'd3,
        UNIT_ELEM = 3'd4
    } op_unit;

    localparam int UNIT_CNT = int'(UNIT_ELEM) + 1;

    typedef enum logic {
        DISP_EMPTY = 1'b0,
        DISP_HELD  = 1'b1
    } disp_state;

endpackage

// File: rtl/vproc_dispatcher_if.sv
// Decoder-to-dispatcher instruction handshake plus the dispatcher-to-unit
// issue handshake; slave is the dispatcher's view, master the environment's.
interface vproc_dispatcher_if #(
    parameter int UNIT_CNT = vproc_pkg::UNIT_CNT,
    parameter int ID_W     = 3
);
    logic                 instr_valid_i;
    logic                 instr_ready_o;
    vproc_pkg::op_unit    instr_unit_i;
    logic [ID_W-1:0]      instr_id_i;
    logic [31:0]          instr_rd_haz_i;
    logic [31:0]          instr_wr_haz_i;
    logic [UNIT_CNT-1:0]  disp_valid_o;
    logic [UNIT_CNT-1:0]  disp_ready_i;
    logic [ID_W-1:0]      disp_id_o;

    modport slave (
        input  instr_valid_i, instr_unit_i, instr_id_i, instr_rd_haz_i,
               instr_wr_haz_i, disp_ready_i,
        output instr_ready_o, disp_valid_o, disp_id_o
    );

    modport master (
        output instr_valid_i, instr_unit_i, instr_id_i, instr_rd_haz_i,
               instr_wr_haz_i, disp_ready_i,
        input  instr_ready_o, disp_valid_o, disp_id_o
    );
endinterface

// File: rtl/vproc_pend_mask.sv
// Per-unit 32-bit pending-vreg register; set and clear take effect next cycle,
// and a bit both set and cleared in the same cycle ends up set.
module vproc_pend_mask (
    input  logic        clk_i,
    input  logic        sync_rst_i,
    input  logic [31:0] set_i,
    input  logic [31:0] clr_i,
    output logic [31:0] mask_o
);
    logic [31:0] mask_q, mask_d;

    always_comb begin
        mask_d = (mask_q & ~clr_i) | set_i;
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_o = mask_q;
endmodule

// File: rtl/vproc_dispatcher.sv
// In-order single-entry dispatcher: accepted instruction can issue the next cycle;
// it is held (counting stall cycles) on RAW/WAW/WAR hazards and held stable under unit backpressure.
module vproc_dispatcher import vproc_pkg::*; #(
    parameter int UNIT_CNT       = vproc_pkg::UNIT_CNT,
    parameter int ID_W           = 3,
    parameter int STALL_CNT_W    = 16,
    parameter bit DONT_CARE_ZERO = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    sync_rst_i,
    vproc_dispatcher_if.slave       disp_if,
    input  logic [UNIT_CNT*32-1:0]  unit_rd_clr_i,
    input  logic [UNIT_CNT*32-1:0]  unit_wr_clr_i,
    output logic [31:0]             pend_rd_o,
    output logic [31:0]             pend_wr_o,
    output logic                    busy_o,
    output logic [STALL_CNT_W-1:0]  stall_cnt_o
);
    disp_state              state_q, state_d;
    op_unit                 unit_q, unit_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [31:0]            rd_haz_q, rd_haz_d;
    logic [31:0]            wr_haz_q, wr_haz_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [31:0]            pend_rd [UNIT_CNT];
    logic [31:0]            pend_wr [UNIT_CNT];
    logic [31:0]            set_rd  [UNIT_CNT];
    logic [31:0]            set_wr  [UNIT_CNT];
    logic [31:0]            pend_rd_all, pend_wr_all;
    logic [UNIT_CNT-1:0]    disp_valid;
    logic                   held, hazard, fire, accept;

    for (genvar u = 0; u < UNIT_CNT; u++) begin : g_unit
        vproc_pend_mask u_pend_rd (
            .clk_i      (clk_i),
            .sync_rst_i (sync_rst_i),
            .set_i      (set_rd[u]),
            .clr_i      (unit_rd_clr_i[u*32 +: 32]),
            .mask_o     (pend_rd[u])
        );
        vproc_pend_mask u_pend_wr (
            .clk_i      (clk_i),
            .sync_rst_i (sync_rst_i),
            .set_i      (set_wr[u]),
            .clr_i      (unit_wr_clr_i[u*32 +: 32]),
            .mask_o     (pend_wr[u])
        );
    end

    always_comb begin
        pend_rd_all = '0;
        pend_wr_all = '0;
        for (int u = 0; u < UNIT_CNT; u++) begin
            pend_rd_all = pend_rd_all | pend_rd[u];
            pend_wr_all = pend_wr_all | pend_wr[u];
        end
    end

    // Checked against registered masks only, so a clear is seen one cycle later.
    assign held   = (state_q == DISP_HELD);
    assign hazard = |((rd_haz_q & pend_wr_all) | (wr_haz_q & pend_wr_all) | (wr_haz_q & pend_rd_all));

    // An out-of-range unit matches no index, so nothing is ever requested for it.
    always_comb begin
        fire = 1'b0;
        for (int u = 0; u < UNIT_CNT; u++) begin
            disp_valid[u] = held && !hazard && (int'(unit_q) == u);
            fire          = fire | (disp_valid[u] & disp_if.disp_ready_i[u]);
            set_rd[u]     = (disp_valid[u] & disp_if.disp_ready_i[u]) ? rd_haz_q : '0;
            set_wr[u]     = (disp_valid[u] & disp_if.disp_ready_i[u]) ? wr_haz_q : '0;
        end
    end

    assign accept = disp_if.instr_valid_i && disp_if.instr_ready_o;

    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        id_d        = id_q;
        rd_haz_d    = rd_haz_q;
        wr_haz_d    = wr_haz_q;
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            state_d  = DISP_HELD;
            unit_d   = disp_if.instr_unit_i;
            id_d     = disp_if.instr_id_i;
            rd_haz_d = disp_if.instr_rd_haz_i;
            wr_haz_d = disp_if.instr_wr_haz_i;
        end else if (fire) begin
            state_d  = DISP_EMPTY;
        end
        if (held && hazard && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q     <= DISP_EMPTY;
            unit_q      <= UNIT_ALU;
            id_q        <= '0;
            rd_haz_q    <= '0;
            wr_haz_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            unit_q      <= unit_d;
            id_q        <= id_d;
            rd_haz_q    <= rd_haz_d;
            wr_haz_q    <= wr_haz_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign disp_if.instr_ready_o = !held || fire;
    assign disp_if.disp_valid_o  = disp_valid;
    assign disp_if.disp_id_o     = (|disp_valid || !DONT_CARE_ZERO) ? id_q : '0;
    assign pend_rd_o             = pend_rd_all;
    assign pend_wr_o             = pend_wr_all;
    assign busy_o                = held || (|pend_rd_all) || (|pend_wr_all);
    assign stall_cnt_o           = stall_cnt_q;

    a_unit_legal: assert property (@(posedge clk_i) disable iff (sync_rst_i)
        (disp_if.instr_valid_i && disp_if.instr_ready_o) |-> (int'(disp_if.instr_unit_i) < UNIT_CNT));
endmodule

// File: tb/tb_vproc_dispatcher.sv
// Directed scenarios followed by random traffic, all checked every cycle against
// a queue-free behavioural model of the dispatcher's issue/pending rules.
module tb_vproc_dispatcher;
    import vproc_pkg::*;

    localparam int NU   = 5;
    localparam int ID_W = 3;
    localparam int SW   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NU*32-1:0]    rd_clr, wr_clr;
    logic [31:0]         pend_rd, pend_wr;
    logic                busy;
    logic [SW-1:0]       stall;

    vproc_dispatcher_if #(.UNIT_CNT(NU), .ID_W(ID_W)) ifc ();

    vproc_dispatcher #(
        .UNIT_CNT(NU), .ID_W(ID_W), .STALL_CNT_W(SW), .DONT_CARE_ZERO(1'b1)
    ) dut (
        .clk_i         (clk),
        .sync_rst_i    (rst),
        .disp_if       (ifc),
        .unit_rd_clr_i (rd_clr),
        .unit_wr_clr_i (wr_clr),
        .pend_rd_o     (pend_rd),
        .pend_wr_o     (pend_wr),
        .busy_o        (busy),
        .stall_cnt_o   (stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: the one held instruction and per-unit sets of busy vregs.
    bit          m_held;
    int          m_unit;
    logic [2:0]  m_id;
    logic [31:0] m_rd, m_wr;
    logic [31:0] m_pr [NU];
    logic [31:0] m_pw [NU];
    int          m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_rd();
        logic [31:0] r = '0;
        for (int u = 0; u < NU; u++) r |= m_pr[u];
        return r;
    endfunction

    function automatic logic [31:0] all_wr();
        logic [31:0] r = '0;
        for (int u = 0; u < NU; u++) r |= m_pw[u];
        return r;
    endfunction

    function automatic bit m_hazard();
        bit raw = (m_rd & all_wr()) != 0;
        bit waw = (m_wr & all_wr()) != 0;
        bit war = (m_wr & all_rd()) != 0;
        return raw || waw || war;
    endfunction

    function automatic logic [NU-1:0] exp_dv();
        logic [NU-1:0] v = '0;
        if (m_held && !m_hazard()) v[m_unit] = 1'b1;
        return v;
    endfunction

    function automatic bit exp_rdy();
        return !m_held || ((exp_dv() & ifc.disp_ready_i) != 0);
    endfunction

    task automatic model_reset();
        m_held = 0; m_unit = 0; m_id = '0; m_rd = '0; m_wr = '0; m_stall = 0;
        for (int u = 0; u < NU; u++) begin
            m_pr[u] = '0;
            m_pw[u] = '0;
        end
    endtask

    task automatic model_step();
        bit fire, acc, haz;
        if (rst) begin
            model_reset();
            return;
        end
        haz  = m_hazard();
        fire = (exp_dv() & ifc.disp_ready_i) != 0;
        acc  = ifc.instr_valid_i && exp_rdy();
        if (m_held && haz && m_stall < (1 << SW) - 1) m_stall++;
        for (int u = 0; u < NU; u++) begin
            m_pr[u] = (m_pr[u] & ~rd_clr[u*32 +: 32]) | ((fire && m_unit == u) ? m_rd : 32'h0);
            m_pw[u] = (m_pw[u] & ~wr_clr[u*32 +: 32]) | ((fire && m_unit == u) ? m_wr : 32'h0);
        end
        if (acc) begin
            m_held = 1;
            m_unit = int'(ifc.instr_unit_i);
            m_id   = ifc.instr_id_i;
            m_rd   = ifc.instr_rd_haz_i;
            m_wr   = ifc.instr_wr_haz_i;
        end else if (fire) begin
            m_held = 0;
        end
    endtask

    task automatic check_all();
        chk("instr_ready", 32'(ifc.instr_ready_o), 32'(exp_rdy()));
        chk("disp_valid", 32'(ifc.disp_valid_o), 32'(exp_dv()));
        if (exp_dv() != 0) chk("disp_id", 32'(ifc.disp_id_o), 32'(m_id));
        chk("pend_rd", pend_rd, all_rd());
        chk("pend_wr", pend_wr, all_wr());
        chk("busy", 32'(busy), 32'(m_held || all_rd() != 0 || all_wr() != 0));
        chk("stall_cnt", 32'(stall), 32'(m_stall));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        check_all();
    endtask

    task automatic set_instr(input bit v, input int unit, input int id,
                             input logic [31:0] rd, input logic [31:0] wr);
        ifc.instr_valid_i  = v;
        ifc.instr_unit_i   = op_unit'(3'(unit));
        ifc.instr_id_i     = 3'(id);
        ifc.instr_rd_haz_i = rd;
        ifc.instr_wr_haz_i = wr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_mask();
        logic [31:0] m = '0;
        if ($urandom_range(0, 2) != 0) m |= 32'h1 << $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) m |= 32'h1 << $urandom_range(0, 7);
        return m;
    endfunction

    initial begin
        rst = 1'b1;
        rd_clr = '0;
        wr_clr = '0;
        ifc.disp_ready_i = '1;
        set_instr(0, 0, 0, 32'h0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all();
        chk("rst_ready", 32'(ifc.instr_ready_o), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Idle issue
        set_instr(1, UNIT_ALU, 1, 32'h0, 32'h10);
        tick();
        set_instr(0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("idle_issue", 32'(ifc.disp_valid_o), 32'h01);
        tick();
        chk("idle_pend_wr", pend_wr, 32'h10);
        wr_clr[0 +: 32] = 32'h10;
        tick();
        wr_clr = '0;

        // RAW on MUL write of v8
        do_reset();
        set_instr(1, UNIT_MUL, 2, 32'h0, 32'h100);
        tick();
        set_instr(1, UNIT_ALU, 3, 32'h100, 32'h1);
        tick();
        set_instr(0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("raw_held", 32'(ifc.disp_valid_o), 32'h0);
        repeat (3) tick();
        chk("raw_stall_cnt", 32'(stall), 32'h3);
        wr_clr[32 +: 32] = 32'h100;
        tick();
        wr_clr = '0;
        #1;
        chk("raw_issue", 32'(ifc.disp_valid_o), 32'h01);
        chk("raw_stall_final", 32'(stall), 32'h4);
        tick();

        // WAR against LSU reads of v2..v3
        do_reset();
        set_instr(1, UNIT_LSU, 4, 32'hC, 32'h0);
        tick();
        set_instr(1, UNIT_ALU, 5, 32'h0, 32'h4);
        tick();
        set_instr(0, 0, 0, 32'h0, 32'h0);
        repeat (2) tick();
        chk("war_stall", 32'(ifc.disp_valid_o), 32'h0);
        rd_clr[64 +: 32] = 32'hC;
        tick();
        rd_clr = '0;
        #1;
        chk("war_issue", 32'(ifc.disp_valid_o), 32'h01);
        tick();

        // Same-cycle set and clear on SLD
        do_reset();
        set_instr(1, UNIT_SLD, 6, 32'h0, 32'h2);
        tick();
        set_instr(0, 0, 0, 32'h0, 32'h0);
        wr_clr[96 +: 32] = 32'h2;
        tick();
        wr_clr = '0;
        chk("collide_set_wins", pend_wr, 32'h2);

        // Backpressure
        do_reset();
        ifc.disp_ready_i = '0;
        set_instr(1, UNIT_ELEM, 7, 32'hF0, 32'h0);
        tick();
        set_instr(1, UNIT_ALU, 0, 32'h0, 32'h1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 32'(ifc.disp_valid_o), 32'h10);
            chk("bp_id", 32'(ifc.disp_id_o), 32'h7);
            chk("bp_ready", 32'(ifc.instr_ready_o), 32'h0);
            chk("bp_stall", 32'(stall), 32'h0);
            tick();
        end
        ifc.disp_ready_i = '1;
        tick();
        set_instr(0, 0, 0, 32'h0, 32'h0);
        tick();

        // Saturating stall, then reset while held
        do_reset();
        set_instr(1, UNIT_MUL, 1, 32'h0, 32'h1);
        tick();
        set_instr(1, UNIT_ALU, 2, 32'h1, 32'h0);
        tick();
        set_instr(0, 0, 0, 32'h0, 32'h0);
        repeat (20) tick();
        chk("sat_stall", 32'(stall), 32'hF);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(ifc.disp_valid_o), 32'h0);
        chk("mid_rst_ready", 32'(ifc.instr_ready_o), 32'h1);
        chk("mid_rst_pend_rd", pend_rd, 32'h0);
        chk("mid_rst_pend_wr", pend_wr, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            set_instr($urandom_range(0, 9) < 6, $urandom_range(0, NU - 1),
                      $urandom_range(0, 7), rand_mask(), rand_mask());
            for (int u = 0; u < NU; u++) begin
                ifc.disp_ready_i[u] = ($urandom_range(0, 9) < 7);
                rd_clr[u*32 +: 32]  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFF) : 32'h0;
                wr_clr[u*32 +: 32]  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFF) : 32'h0;
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
